hus_mixer: RTL
==============

Name: hus_mixer

Overview:
- Parametrised successor to the single-shot sample engine. Runs a frame per audio tick: fetches one sample per channel, multiplies by per-channel left/right volume, accumulates, saturates, and presents a stereo pair.
- Sits between the ZX-port register interface (volume writes) and the DAC serialiser.
- Sample memory sits behind a req/ack handshake, owned by the bus arbiter.

Parameters:
- CHN_NUM, 32: channel count, 1..64.
- AU_DIV, 544: clk cycles per audio frame (24 MHz / 44.1 kHz).
- SMP_W, 8: signed sample width.
- VOL_W, 6: unsigned volume width.
- OUT_W, 16: signed output width.
- OUT_SHIFT, 2: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  engine run enable.
- reg_we  in  1  volume register write strobe.
- reg_addr  in  $clog2(CHN_NUM)+1  {channel, lr}; lr=0 left, lr=1 right.
- reg_wdata  in  VOL_W  volume value.
- smp_req  out  1  sample fetch request.
- smp_chn  out  $clog2(CHN_NUM)  channel being fetched.
- smp_ack  in  1  fetch complete; smp_data valid this cycle.
- smp_data  in  SMP_W  signed sample.
- out_l, out_r  out  OUT_W  signed mixed output.
- out_stb  out  1  one-cycle pulse when out_l/out_r update.
- busy  out  1  high in any state other than IDLE/OFF.
- overrun  out  1  sticky flag: frame not finished when the next tick arrived.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (async, reset_n=0): state=OFF, all counters 0, volume file 0, sample buffer 0, accumulators 0, outputs 0, smp_req=0, out_stb=0, overrun=0.
- Tick counter:
  - Counts 0..AU_DIV-1 and wraps.
  - au_stb is high for one cycle when the count equals AU_DIV-1.
  - Free-runs only while enable=1; held at 0 otherwise.
- FSM states: OFF, IDLE, BURST, MATH, OUT.
  - OFF -> IDLE when enable=1.
  - IDLE -> BURST on au_stb. chn_cnt=0; accumulators cleared.
  - BURST:
    - smp_req=1, smp_chn=chn_cnt.
    - On smp_ack: store smp_data into buf[chn_cnt] and increment chn_cnt.
    - On ack of channel CHN_NUM-1: drop smp_req the next cycle, chn_cnt=0, -> MATH.
    - smp_req stays high across back-to-back acks; one ack per cycle maximum.
  - MATH:
    - One channel per cycle: acc_l += buf[c]*vol_l[c] and acc_r += buf[c]*vol_r[c], signed x unsigned.
    - Product width SMP_W+VOL_W+1; accumulator width SMP_W+VOL_W+1+$clog2(CHN_NUM).
    - After channel CHN_NUM-1 -> OUT.
  - OUT:
    - out_x = sat_OUT_W(acc_x >>> OUT_SHIFT). Saturation limits are +2^(OUT_W-1)-1 and -2^(OUT_W-1).
    - out_stb=1 for exactly this cycle. -> IDLE.
- Frame latency: au_stb to out_stb = 1 + (cycles to CHN_NUM acks) + CHN_NUM + 1 cycles. With zero-wait acks this is 2*CHN_NUM+2 cycles.
- Overrun:
  - If au_stb occurs while the state is BURST, MATH or OUT: overrun<=1, the tick is dropped, and the current frame completes normally.
  - ovr_clr and a new overrun in the same cycle: set wins.
- enable deassert in any state:
  - Next cycle: state=OFF, smp_req=0, chn_cnt=0. The partial frame is discarded.
  - out_l/out_r hold their last values; no out_stb.
  - An ack arriving in that cycle is ignored.
- Volume writes:
  - Accepted in every state, including OFF.
  - Visible from the next cycle.
  - A write to the channel being processed in that same MATH cycle uses the old value.
- Addresses with channel >= CHN_NUM are ignored.
- busy = state is BURST, MATH or OUT.

Test Plan:
- Reset with enable=1 and zero-wait acks, all volumes 0 -> out_stb every 544 cycles; out_l=out_r=0; overrun=0.
- Channel 0 sample +100, vol_l[0]=63, vol_r[0]=0, others 0 -> out_l=(6300>>>2)=1575, out_r=0; au_stb to out_stb = 66 cycles.
- All 32 channels sample -128, vol_l=vol_r=63 -> accumulator -258048, shifted -64512, saturated out_l=out_r=-32768.
- ack delayed 20 cycles per channel (frame > 544 cycles) -> overrun=1 after the first late tick; frames still emit out_stb; ovr_clr -> overrun=0 unless re-set in the same cycle.
- enable dropped mid-BURST at channel 10 -> smp_req low next cycle; no out_stb; outputs hold. Re-enable -> a clean frame starts at channel 0 on the next au_stb.
- reset_n pulsed low mid-MATH (async, between clk edges) -> all outputs 0 immediately; volume file cleared; state OFF.

Source files
------------

// File: rtl/hus_mixer.sv
// hus_mixer: frame-based multi-channel sample mixer.
// Each audio tick fetches one sample per channel over a req/ack port,
// scales it by the per-channel left/right volumes, accumulates, and
// presents a saturated stereo pair with a one-cycle strobe.
module hus_mixer #(
    parameter int CHN_NUM   = 32,
    parameter int AU_DIV    = 544,
    parameter int SMP_W     = 8,
    parameter int VOL_W     = 6,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 2,
    localparam int CHN_W    = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             reg_we,
    input  logic [CHN_W:0]   reg_addr,
    input  logic [VOL_W-1:0] reg_wdata,
    output logic             smp_req,
    output logic [CHN_W-1:0] smp_chn,
    input  logic             smp_ack,
    input  logic [SMP_W-1:0] smp_data,
    output logic [OUT_W-1:0] out_l,
    output logic [OUT_W-1:0] out_r,
    output logic             out_stb,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int TICK_W = (AU_DIV > 1) ? $clog2(AU_DIV) : 1;
    localparam int PROD_W = SMP_W + VOL_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(CHN_NUM);
    localparam int SAT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [SAT_W-1:0] SAT_MAX   = SAT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SAT_W-1:0] SAT_MIN   = ~SAT_MAX;
    localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(AU_DIV - 1);
    localparam logic [CHN_W-1:0]        CHN_LAST  = CHN_W'(CHN_NUM - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_BURST,
        S_MATH,
        S_OUT
    } state_e;

    state_e                  state_q, state_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [CHN_W-1:0]        chn_q, chn_d;
    logic signed [SMP_W-1:0] smp_buf_q [CHN_NUM];
    logic [VOL_W-1:0]        vol_l_q [CHN_NUM];
    logic [VOL_W-1:0]        vol_r_q [CHN_NUM];
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
    logic signed [OUT_W-1:0] out_l_q, out_l_d;
    logic signed [OUT_W-1:0] out_r_q, out_r_d;
    logic                    out_stb_q, out_stb_d;
    logic                    ovr_q, ovr_d;

    logic                     au_stb;
    logic                     busy_w;
    logic                     chn_last;
    logic                     buf_we;
    logic [CHN_W-1:0]         wr_ch;
    logic                     wr_lr;
    logic                     wr_ok;
    logic signed [PROD_W-1:0] smp_x, vol_l_x, vol_r_x;
    logic signed [PROD_W-1:0] prod_l, prod_r;

    // Arithmetic shift then clamp to the signed output range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [SAT_W-1:0] w;
        w = SAT_W'(a >>> OUT_SHIFT);
        if (w > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end
        if (w < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return w[OUT_W-1:0];
    endfunction

    // Audio tick divider: free-runs only while enabled.
    always_comb begin
        au_stb = enable && (tick_q == TICK_LAST);
        tick_d = (!enable || au_stb) ? '0 : tick_q + 1'b1;
    end

    // Decode of the volume register address and the per-channel products.
    always_comb begin
        wr_ch   = reg_addr[CHN_W:1];
        wr_lr   = reg_addr[0];
        wr_ok   = reg_we && ({1'b0, wr_ch} < (CHN_W + 1)'(CHN_NUM));
        chn_last = (chn_q == CHN_LAST);
        busy_w  = (state_q == S_BURST) || (state_q == S_MATH) || (state_q == S_OUT);
        smp_x   = PROD_W'(smp_buf_q[chn_q]);
        vol_l_x = PROD_W'(vol_l_q[chn_q]);
        vol_r_x = PROD_W'(vol_r_q[chn_q]);
        prod_l  = smp_x * vol_l_x;
        prod_r  = smp_x * vol_r_x;
    end

    // Next-state, channel counter, accumulator and output-register logic.
    always_comb begin
        state_d   = state_q;
        chn_d     = chn_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        out_stb_d = 1'b0;
        buf_we    = 1'b0;
        if (!enable) begin
            // Disabling abandons any partial frame; outputs keep their last values.
            state_d = S_OFF;
            chn_d   = '0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (au_stb) begin
                        state_d = S_BURST;
                        chn_d   = '0;
                        acc_l_d = '0;
                        acc_r_d = '0;
                    end
                end
                S_BURST: begin
                    if (smp_ack) begin
                        buf_we = 1'b1;
                        if (chn_last) begin
                            chn_d   = '0;
                            state_d = S_MATH;
                        end else begin
                            chn_d = chn_q + 1'b1;
                        end
                    end
                end
                S_MATH: begin
                    acc_l_d = acc_l_q + ACC_W'(prod_l);
                    acc_r_d = acc_r_q + ACC_W'(prod_r);
                    if (chn_last) begin
                        chn_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        chn_d = chn_q + 1'b1;
                    end
                end
                S_OUT: begin
                    out_l_d   = sat_out(acc_l_q);
                    out_r_d   = sat_out(acc_r_q);
                    out_stb_d = 1'b1;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end
    end

    // Sticky overrun: a tick landing in an active frame sets it; set beats clear.
    always_comb begin
        if (au_stb && busy_w) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State, counters, accumulators and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_OFF;
            tick_q    <= '0;
            chn_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            out_stb_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            chn_q     <= chn_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            out_stb_q <= out_stb_d;
            ovr_q     <= ovr_d;
        end
    end

    // Sample buffer filled during the fetch burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp_buf_q <= '{default: '0};
        end else if (buf_we) begin
            smp_buf_q[chn_q] <= smp_data;
        end
    end

    // Volume file; writes are accepted in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vol_l_q <= '{default: '0};
            vol_r_q <= '{default: '0};
        end else if (wr_ok) begin
            if (wr_lr) begin
                vol_r_q[wr_ch] <= reg_wdata;
            end else begin
                vol_l_q[wr_ch] <= reg_wdata;
            end
        end
    end

    assign smp_req = (state_q == S_BURST);
    assign smp_chn = chn_q;
    assign out_l   = out_l_q;
    assign out_r   = out_r_q;
    assign out_stb = out_stb_q;
    assign busy    = busy_w;
    assign overrun = ovr_q;

endmodule
